// File: rtl/reg_dump_uart_tx_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reg_dump_uart_tx_if : request/observation bus plus UART status for the dump TX
// Revision: 1.0
// ---------------------------------------------------------------------------
interface reg_dump_uart_tx_if;
  logic               dump_req;
  logic [15:0][31:0]  leds_registers;
  logic [31:0]        PC_led;
  logic               tx;
  logic               busy;
  logic               done;

  modport master (
    output dump_req,
    output leds_registers,
    output PC_led,
    input  tx,
    input  busy,
    input  done
  );

  modport slave (
    input  dump_req,
    input  leds_registers,
    input  PC_led,
    output tx,
    output busy,
    output done
  );
endinterface
`default_nettype wire

// File: rtl/reg_dump_uart_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reg_dump_uart_tx : snapshots PC + 16 registers, sends a 70-byte 8N1 frame
// Revision: 1.0
// ---------------------------------------------------------------------------
module reg_dump_uart_tx #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BAUD         = 115_200,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
  input  logic              clk,
  input  logic              reset,
  reg_dump_uart_tx_if.slave bus
);

  localparam int              CNT_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] c_baud_last = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [6:0]      c_last_byte = 7'd69;
  localparam logic [6:0]      c_first_reg = 7'd5;
  localparam logic [7:0]      c_header    = 8'hA5;

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("CLKS_PER_BIT must be at least 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t            r_state,     w_state_nxt;
  logic [CNT_W-1:0]  r_baud,      w_baud_nxt;
  logic [2:0]        r_bit_idx,   w_bit_idx_nxt;
  logic [6:0]        r_byte_idx,  w_byte_idx_nxt;
  logic [7:0]        r_shift,     w_shift_nxt;
  logic [7:0]        r_csum,      w_csum_nxt;
  logic [31:0]       r_snap_pc,   w_snap_pc_nxt;
  logic [15:0][31:0] r_snap_regs, w_snap_regs_nxt;
  logic              r_tx,        w_tx_nxt;
  logic              r_busy,      w_busy_nxt;
  logic              r_done,      w_done_nxt;

  logic [6:0]        w_next_idx;
  logic [5:0]        w_reg_off;
  logic [1:0]        w_pc_sel;
  logic [7:0]        w_next_byte;
  logic              w_next_is_payload;
  logic              w_bit_end;

  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] sel);
    case (sel)
      2'd0:    return word[31:24];
      2'd1:    return word[23:16];
      2'd2:    return word[15:8];
      default: return word[7:0];
    endcase
  endfunction

  // Byte that follows the one currently on the wire, taken from the frozen snapshot
  assign w_next_idx        = r_byte_idx + 7'd1;
  assign w_reg_off         = 6'(w_next_idx - c_first_reg);
  assign w_pc_sel          = 2'(w_next_idx - 7'd1);
  assign w_next_is_payload = (w_next_idx != c_last_byte);
  assign w_bit_end         = (r_baud == c_baud_last);

  always_comb begin
    w_next_byte = word_byte(r_snap_pc, w_pc_sel);
    if (w_next_idx == c_last_byte) begin
      w_next_byte = r_csum;
    end else if (w_next_idx >= c_first_reg) begin
      w_next_byte = word_byte(r_snap_regs[w_reg_off[5:2]], w_reg_off[1:0]);
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_baud_nxt      = r_baud;
    w_bit_idx_nxt   = r_bit_idx;
    w_byte_idx_nxt  = r_byte_idx;
    w_shift_nxt     = r_shift;
    w_csum_nxt      = r_csum;
    w_snap_pc_nxt   = r_snap_pc;
    w_snap_regs_nxt = r_snap_regs;
    w_tx_nxt        = r_tx;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_tx_nxt = 1'b1;
        // A request coinciding with the done pulse is dropped, not queued
        if (bus.dump_req && !r_busy && !r_done) begin
          w_snap_pc_nxt   = bus.PC_led;
          w_snap_regs_nxt = bus.leds_registers;
          w_byte_idx_nxt  = 7'd0;
          w_csum_nxt      = 8'h00;
          w_shift_nxt     = c_header;
          w_baud_nxt      = '0;
          w_bit_idx_nxt   = 3'd0;
          w_busy_nxt      = 1'b1;
          w_tx_nxt        = 1'b0;
          w_state_nxt     = ST_START;
        end
      end

      ST_START: begin
        if (w_bit_end) begin
          w_baud_nxt    = '0;
          w_bit_idx_nxt = 3'd0;
          w_tx_nxt      = r_shift[0];
          w_shift_nxt   = {1'b0, r_shift[7:1]};
          w_state_nxt   = ST_DATA;
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end

      ST_DATA: begin
        if (w_bit_end) begin
          w_baud_nxt = '0;
          if (r_bit_idx == 3'd7) begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = ST_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
            w_tx_nxt      = r_shift[0];
            w_shift_nxt   = {1'b0, r_shift[7:1]};
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end

      ST_STOP: begin
        if (w_bit_end) begin
          w_baud_nxt = '0;
          if (r_byte_idx < c_last_byte) begin
            w_byte_idx_nxt = w_next_idx;
            w_shift_nxt    = w_next_byte;
            if (w_next_is_payload) begin
              w_csum_nxt = r_csum ^ w_next_byte;
            end
            w_tx_nxt    = 1'b0;
            w_state_nxt = ST_START;
          end else begin
            w_tx_nxt    = 1'b1;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end

      default: begin
        w_tx_nxt    = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_baud      <= '0;
      r_bit_idx   <= 3'd0;
      r_byte_idx  <= 7'd0;
      r_shift     <= 8'h00;
      r_csum      <= 8'h00;
      r_snap_pc   <= 32'h0;
      r_snap_regs <= '0;
      r_tx        <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_baud      <= w_baud_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_byte_idx  <= w_byte_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_csum      <= w_csum_nxt;
      r_snap_pc   <= w_snap_pc_nxt;
      r_snap_regs <= w_snap_regs_nxt;
      r_tx        <= w_tx_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign bus.tx   = r_tx;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_reg_dump_uart_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_reg_dump_uart_tx : scoreboard bench, UART-decoding monitor vs frame model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_reg_dump_uart_tx;

  localparam int CPB       = 4;
  localparam int FRAME_CYC = 700 * CPB;

  logic clk;
  logic reset;

  reg_dump_uart_tx_if bus_if ();

  reg_dump_uart_tx #(
    .CLK_HZ       (50_000_000),
    .BAUD         (115_200),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];

  int   cyc = 0;
  int   done_cnt = 0;
  int   rx_byte_cnt = 0;
  bit   rx_active = 0;
  int   rx_pos = 0;
  logic rx_samp[40];
  int   t0 = 0;
  bit   expect_start = 0;
  bit   done_next = 0;
  logic prev_busy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference frame built straight from the current bus inputs
  function automatic void push_frame();
    logic [7:0] b;
    logic [7:0] cs;
    cs = 8'h00;
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 4; i++) begin
      b = 8'(bus_if.PC_led >> (24 - 8 * i));
      exp_q.push_back(b);
      cs ^= b;
    end
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 4; i++) begin
        b = 8'(bus_if.leds_registers[k] >> (24 - 8 * i));
        exp_q.push_back(b);
        cs ^= b;
      end
    end
    exp_q.push_back(cs);
  endfunction

  task automatic randomize_inputs();
    bus_if.PC_led = $urandom();
    for (int k = 0; k < 16; k++) bus_if.leds_registers[k] = $urandom();
  endtask

  task automatic issue_req();
    @(posedge clk); #1;
    bus_if.dump_req = 1'b1;
    @(posedge clk);
    push_frame();
    #1;
    bus_if.dump_req = 1'b0;
    check("start_latency", {bus_if.tx, bus_if.busy}, 2'b01);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (bus_if.done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", (n < budget), 1);
  endtask

  task automatic decode_byte();
    bit         ok;
    logic [7:0] b;
    logic [7:0] e;
    ok = 1'b1;
    for (int j = 0; j < 40; j++) begin
      if (j < 4)        ok &= (rx_samp[j] === 1'b0);
      else if (j >= 36) ok &= (rx_samp[j] === 1'b1);
      else              ok &= (rx_samp[j] === rx_samp[4 + 4 * ((j - 4) / 4)]);
    end
    for (int i = 0; i < 8; i++) b[i] = rx_samp[4 + 4 * i];
    check($sformatf("bit_timing_b%0d", rx_byte_cnt), ok, 1);
    check("byte_expected", (exp_q.size() != 0), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check($sformatf("byte%0d", rx_byte_cnt), b, e);
    end
    if (rx_byte_cnt == 69) begin
      check("frame_len", cyc - t0 + 1, FRAME_CYC);
      done_next   = 1'b1;
      rx_byte_cnt = 0;
    end else begin
      rx_byte_cnt++;
      expect_start = 1'b1;
    end
  endtask

  // Monitor: decodes the serial line one sample per clock, away from the edge
  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        rx_active    = 1'b0;
        rx_pos       = 0;
        rx_byte_cnt  = 0;
        expect_start = 1'b0;
        done_next    = 1'b0;
      end else begin
        if (done_next) begin
          check("done_after_frame", {bus_if.done, bus_if.busy}, 2'b10);
          check("busy_before_done", prev_busy, 1'b1);
          done_next = 1'b0;
        end
        if (bus_if.done === 1'b1) done_cnt++;
        if (!rx_active) begin
          if (expect_start) begin
            check("no_gap", bus_if.tx, 1'b0);
            expect_start = 1'b0;
          end
          if (bus_if.tx === 1'b0) begin
            rx_active = 1'b1;
            rx_pos    = 0;
            if (rx_byte_cnt == 0) t0 = cyc;
          end
        end
        if (rx_active) begin
          rx_samp[rx_pos] = bus_if.tx;
          rx_pos++;
          if (rx_pos == 40) begin
            decode_byte();
            rx_active = 1'b0;
          end
        end
      end
      prev_busy = bus_if.busy;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int base;
    reset              = 1'b0;
    bus_if.dump_req    = 1'b0;
    bus_if.PC_led      = 32'h0;
    bus_if.leds_registers = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {bus_if.tx, bus_if.busy, bus_if.done}, 3'b100);
    reset = 1'b1;
    repeat (50) begin
      @(posedge clk); #1;
      check("idle_outputs", {bus_if.tx, bus_if.busy, bus_if.done}, 3'b100);
    end

    // Basic frame with known contents
    bus_if.PC_led = 32'h0000_0010;
    for (int k = 0; k < 16; k++) bus_if.leds_registers[k] = 32'h1111_1111 * k;
    issue_req();
    wait_done(FRAME_CYC + 100);
    repeat (3) @(negedge clk);
    check("done_count_basic", done_cnt, 1);

    // Inputs change right after acceptance; frame must carry the old values
    issue_req();
    @(posedge clk); #1;
    bus_if.PC_led = 32'hDEAD_BEEF;
    for (int k = 0; k < 16; k++) bus_if.leds_registers[k] = $urandom();
    wait_done(FRAME_CYC + 100);
    repeat (3) @(negedge clk);
    check("done_count_freeze", done_cnt, 2);

    // Requests while busy, on the done cycle, then the cycle after done
    randomize_inputs();
    issue_req();
    repeat (100) @(posedge clk);
    #1 bus_if.dump_req = 1'b1;
    @(posedge clk);
    #1 bus_if.dump_req = 1'b0;
    repeat (FRAME_CYC - 1 - 101) @(posedge clk);
    #1 bus_if.dump_req = 1'b1;
    @(posedge clk); #1;
    check("done_at_2800", {bus_if.done, bus_if.busy}, 2'b10);
    randomize_inputs();
    @(posedge clk); #1;
    check("req_on_done_ignored", {bus_if.tx, bus_if.busy, bus_if.done}, 3'b100);
    @(posedge clk);
    push_frame();
    #1 bus_if.dump_req = 1'b0;
    check("req_after_done_accepted", {bus_if.tx, bus_if.busy}, 2'b01);
    wait_done(FRAME_CYC + 100);
    repeat (3) @(negedge clk);
    check("done_count_busy", done_cnt, 4);

    // Reset in the middle of byte 20
    randomize_inputs();
    issue_req();
    base = 0;
    while (rx_byte_cnt != 20 && base < FRAME_CYC) begin
      @(posedge clk);
      base++;
    end
    check("reach_byte20_timeout", (base < FRAME_CYC), 1);
    repeat (10) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_outputs", {bus_if.tx, bus_if.busy}, 2'b10);
    exp_q.delete();
    base = done_cnt;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("no_done_after_abort", done_cnt, base);
    check("idle_after_abort", {bus_if.tx, bus_if.busy}, 2'b10);
    randomize_inputs();
    issue_req();
    wait_done(FRAME_CYC + 100);
    repeat (3) @(negedge clk);
    check("done_count_after_abort", done_cnt, base + 1);

    // Random frames with random idle gaps and mid-frame input churn
    for (int f = 0; f < 2; f++) begin
      repeat ($urandom_range(1, 20)) @(posedge clk);
      randomize_inputs();
      issue_req();
      repeat ($urandom_range(1, 500)) @(posedge clk);
      #1 randomize_inputs();
      wait_done(FRAME_CYC + 100);
    end
    repeat (5) @(negedge clk);
    check("done_count_final", done_cnt, base + 3);
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_dump_uart_tx.md
Name: reg_dump_uart_tx

Overview:
- Debug readout path for the Proyecto2 processor. It consumes the processor's register-view bus (leds_registers) and PC_led, which the processor only exposes as observation outputs.
- On a dump request it snapshots all 16 registers plus the PC and serializes them as one framed, checksummed packet over a UART 8N1 transmit line for host-side inspection.
- Sits beside the processor top in the 50 MHz clock domain.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 115200, UART bit rate.
- CLKS_PER_BIT, CLK_HZ/BAUD (434), clocks per UART bit. Must be >= 2; the bench overrides it to 4.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- dump_req  in  1  single-cycle request to start a dump.
- leds_registers  in  16x32 (packed [15:0][31:0])  processor register view; entry k = register k.
- PC_led  in  32  processor program counter.
- tx  out  1  UART serial output; idle high.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset values (asserted asynchronously, immediately): tx=1, busy=0, done=0, FSM=IDLE, all counters 0, snapshot registers 0.
- Frame is 70 bytes:
  - byte 0: header 0xA5.
  - bytes 1-4: PC, MSB first.
  - bytes 5-68: registers 0..15, each 4 bytes MSB first.
  - byte 69: checksum = XOR of bytes 1..68. The header is excluded.
- Byte format: start bit (0), 8 data bits LSB first, stop bit (1). Each bit is held exactly CLKS_PER_BIT cycles.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on a rising clk edge where dump_req=1 and busy=0. At that same edge: PC_led and leds_registers are latched into the snapshot, byte index = 0, checksum accumulator = 0, busy goes 1.
  - START: tx=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: bit index runs 0..7, each bit held CLKS_PER_BIT cycles -> STOP after bit 7.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then:
    - if byte index < 69: increment byte index -> START (no idle gap between bytes);
    - else -> IDLE, busy=0, done=1 for exactly one cycle.
- Latency: tx falls (start bit of header) on the first clock after the accepting edge. Total frame length from first start bit to end of last stop bit is 700*CLKS_PER_BIT cycles. done asserts on the cycle after the last stop-bit cycle.
- The checksum accumulates each payload byte as it is loaded into the shift register.
- dump_req while busy=1 is ignored, including on the same cycle done pulses. No queuing.
- The snapshot is frozen for the whole frame. Input changes after the accepting edge do not alter the transmitted data.
- Reset asserted mid-frame aborts immediately: tx=1, busy=0, and no done pulse. After release, the block waits in IDLE for a new dump_req.
- Baud counter: counts 0..CLKS_PER_BIT-1, wraps at the end of each bit. No fractional-baud correction.
- tx is driven from a register; no combinational glitch path to the pin.

Test Plan:
- Reset/idle: hold reset=0 for 3 cycles, then release with no dump_req for 50 cycles -> tx=1, busy=0, done=0 throughout.
- Basic frame (CLKS_PER_BIT=4): PC_led=0x00000010, register k = 0x11111111*k, pulse dump_req -> decoded bytes are A5, 00 00 00 10, then 00 00 00 00, 11 11 11 11 ... FF FF FF FF, then checksum 0x10. Frame spans 2800 cycles; done pulses once; busy falls on the same cycle done rises.
- Snapshot freeze: change PC_led to 0xDEADBEEF one cycle after acceptance -> frame still carries 0x00000010 and checksum 0x10.
- Request while busy: pulse dump_req at cycles 100 and 2799 after start -> exactly one frame and one done. A dump_req on the cycle after done starts a new frame.
- Reset mid-frame: assert reset during byte 20 -> tx=1 and busy=0 within the same cycle, no done. A fresh dump_req afterwards produces a complete, correct 70-byte frame.
- Bit timing: measure every tx edge in the basic frame -> each bit is exactly 4 cycles wide, start bit is 0, stop bit is 1, data bits are LSB first (header bit sequence 1,0,1,0,0,1,0,1).
